// File: rtl/sram_if_pkg.sv
// Shared definitions for the SRAM-like req/addr_ok/data_ok bus.
package sram_if_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam logic [7:0] LFSR_SEED = 8'h5A;

  // One accepted request waiting for its response slot.
  typedef struct packed {
    logic              wr;
    logic [DATA_W-1:0] data;
  } resp_t;
endpackage

// File: rtl/sram_like_slave_resp_fifo.sv
// In-order response queue; each entry counts down its own latency and only
// the head may leave, so responses return strictly in acceptance order.
module resp_fifo
  import sram_if_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  resp_t                    push_data,
  input  logic                     pop,
  output logic                     head_ready,
  output resp_t                    head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int TW = $clog2(LATENCY + 1);
  localparam logic [TW-1:0] CNT_INIT = TW'(LATENCY - 1);
  localparam logic [PW:0]   DEPTH_C  = (PW + 1)'(DEPTH);

  resp_t           ent_data [DEPTH];
  logic [TW-1:0]   ent_cnt  [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     count_r;

  assign head_ready = (count_r != '0) && (ent_cnt[rd_ptr] == '0);
  assign head       = ent_data[rd_ptr];
  assign count      = count_r;

  // Stale slots may keep counting down; they are overwritten on the next push.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
      for (int i = 0; i < DEPTH; i++) ent_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_cnt[i] != '0) ent_cnt[i] <= ent_cnt[i] - 1'b1;
      end
      if (push) begin
        ent_cnt[wr_ptr] <= CNT_INIT;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) ent_data[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push && !pop && count_r == DEPTH_C));
      assert (!(pop && !head_ready));
    end
  end
endmodule

// File: rtl/sram_like_slave.sv
// Responder for the SRAM-like bus: word memory with byte writes, bounded
// outstanding requests, fixed response latency and optional addr_ok throttling.
module sram_like_slave
  import sram_if_pkg::*;
#(
  parameter int MEM_AW     = 12,
  parameter int DEPTH      = 4,
  parameter int LATENCY    = 2,
  parameter int RAND_STALL = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic [3:0]        wstrb,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              addr_ok,
  output logic              data_ok,
  output logic [DATA_W-1:0] rdata
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DATA_W-1:0] mem [2**MEM_AW];
  logic [MEM_AW-1:0] idx;
  logic              reset_q;
  logic [7:0]        lfsr;
  logic [CW-1:0]     count;
  logic              head_ready;
  logic              accept;
  resp_t             head;
  resp_t             push_ent;
  logic              unused_bits;

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                    input logic [DATA_W-1:0] new_w,
                                                    input logic [3:0]        strb);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  // size is informational and upper address bits alias onto the memory.
  assign unused_bits = ^{size, addr[ADDR_W-1:MEM_AW+2], addr[1:0]};

  assign idx     = addr[MEM_AW+1:2];
  // No bypass: a full queue refuses even when the head pops this cycle.
  assign addr_ok = !reset_q && (count < DEPTH_C) &&
                   ((RAND_STALL == 0) || (lfsr[1:0] != 2'b00));
  assign accept  = req && addr_ok && !reset;

  // Reads sample the array at the accept edge, so earlier writes are visible.
  assign push_ent.wr   = wr;
  assign push_ent.data = mem[idx];

  always_ff @(posedge clk) begin
    if (accept && wr) mem[idx] <= merge_bytes(mem[idx], wdata, wstrb);
  end

  resp_fifo #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) u_resp_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (accept),
    .push_data  (push_ent),
    .pop        (head_ready),
    .head_ready (head_ready),
    .head       (head),
    .count      (count)
  );

  // Response stage: head pop becomes a one-cycle data_ok pulse.
  always_ff @(posedge clk) begin
    reset_q <= reset;
    if (reset) begin
      lfsr    <= LFSR_SEED;
      data_ok <= 1'b0;
      rdata   <= '0;
    end else begin
      if (RAND_STALL != 0) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      data_ok <= head_ready;
      rdata   <= (head_ready && !head.wr) ? head.data : '0;
    end
  end
endmodule

// File: tb/tb_sram_like_slave.sv
// Scoreboard bench: three slave instances (short latency, long latency,
// random stall) each tracked by a reference memory and expected-response queue.
module tb_sram_like_slave;
  typedef struct {
    logic [31:0] data;
    int          edge_n;
  } exp_t;

  logic        clk;
  int          cyc;
  int          n_checks;
  int          n_fail;
  int          acc_cnt [3];
  int          rsp_cnt [3];

  logic        reset_a [3];
  logic        req_a   [3];
  logic        wr_a    [3];
  logic [1:0]  size_a  [3];
  logic [3:0]  wstrb_a [3];
  logic [31:0] addr_a  [3];
  logic [31:0] wdata_a [3];
  logic        aok     [3];
  logic        dok     [3];
  logic [31:0] rdata_a [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int LAT = (g == 1) ? 8 : 2;
    localparam int RS  = (g == 2) ? 1 : 0;

    exp_t        q[$];
    logic [31:0] mdl [int unsigned];
    logic        rstq;
    logic [7:0]  lf;
    int unsigned idx;
    logic [31:0] old;
    exp_t        e;

    sram_like_slave #(
      .MEM_AW     (12),
      .DEPTH      (4),
      .LATENCY    (LAT),
      .RAND_STALL (RS)
    ) dut (
      .clk     (clk),
      .reset   (reset_a[g]),
      .req     (req_a[g]),
      .wr      (wr_a[g]),
      .size    (size_a[g]),
      .wstrb   (wstrb_a[g]),
      .addr    (addr_a[g]),
      .wdata   (wdata_a[g]),
      .addr_ok (aok[g]),
      .data_ok (dok[g]),
      .rdata   (rdata_a[g])
    );

    always @(posedge clk) begin
      rstq <= reset_a[g];
      if (reset_a[g]) lf <= 8'h5A;
      else if (RS != 0) lf <= {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
    end

    always @(negedge clk) begin
      if (cyc > 0) begin
        if (dok[g]) begin
          if (q.size() == 0) begin
            chk($sformatf("unexpected_data_ok%0d", g), 32'(dok[g]), 32'd0);
          end else begin
            e = q.pop_front();
            chk($sformatf("rdata%0d", g), rdata_a[g], e.data);
            chk($sformatf("latency%0d", g), 32'(cyc - e.edge_n), 32'(LAT));
            rsp_cnt[g]++;
          end
        end else if (q.size() > 0 && (cyc - q[0].edge_n) > LAT) begin
          chk($sformatf("missing_data_ok%0d", g), 32'(dok[g]), 32'd1);
          void'(q.pop_front());
        end
        chk($sformatf("addr_ok%0d", g), 32'(aok[g]),
            32'(!rstq && q.size() < 4 && (RS == 0 || lf[1:0] != 2'b00)));
        if (reset_a[g]) begin
          acc_cnt[g] -= q.size();
          q.delete();
        end else if (req_a[g] && aok[g]) begin
          idx = (addr_a[g] >> 2) & 32'hFFF;
          old = mdl.exists(idx) ? mdl[idx] : 32'h0;
          if (wr_a[g]) begin
            for (int b = 0; b < 4; b++) begin
              if (wstrb_a[g][b]) old[8*b +: 8] = wdata_a[g][8*b +: 8];
            end
            mdl[idx] = old;
            e.data = 32'h0;
          end else begin
            e.data = old;
          end
          e.edge_n = cyc + 1;
          q.push_back(e);
          acc_cnt[g]++;
        end
      end
    end
  end

  task automatic issue(input int i, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    logic acc;
    acc = 1'b0;
    req_a[i] = 1'b1; wr_a[i] = w; addr_a[i] = a; wdata_a[i] = d; wstrb_a[i] = s;
    size_a[i] = 2'd2;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      acc = aok[i];
      @(posedge clk);
      #1;
    end
    req_a[i] = 1'b0;
    chk("issue_accepted", 32'(acc), 32'd1);
  endtask

  task automatic drain(input int i);
    for (int n = 0; n < 100 && acc_cnt[i] != rsp_cnt[i]; n++) @(posedge clk);
    #1;
    chk($sformatf("drain%0d", i), 32'(rsp_cnt[i]), 32'(acc_cnt[i]));
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 3; i++) begin
      acc_cnt[i] = 0; rsp_cnt[i] = 0;
      reset_a[i] = 1'b1; req_a[i] = 1'b0; wr_a[i] = 1'b0; size_a[i] = 2'd0;
      wstrb_a[i] = 4'h0; addr_a[i] = 32'h0; wdata_a[i] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_addr_ok", 32'(aok[i]), 32'd0);
      chk("rst_data_ok", 32'(dok[i]), 32'd0);
      chk("rst_rdata", rdata_a[i], 32'h0);
      reset_a[i] = 1'b0;
    end

    // Short-latency instance: full write, byte write, empty strobe, aliasing.
    issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0);
    issue(0, 1'b1, 32'h20, 32'h11223344, 4'hF);
    issue(0, 1'b1, 32'h20, 32'h0000AB00, 4'b0010);
    issue(0, 1'b0, 32'h20, 32'h0, 4'h0);
    issue(0, 1'b1, 32'h10, 32'h55555555, 4'h0);
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0);
    issue(0, 1'b0, 32'h0001_0010, 32'h0, 4'h0);
    issue(0, 1'b1, 32'h3FFC, 32'hA5A5_0F0F, 4'hF);
    issue(0, 1'b0, 32'h3FFC, 32'h0, 4'h0);
    drain(0);

    // Long-latency instance: fill the queue, stall, pop-without-bypass.
    for (int k = 0; k < 6; k++) issue(1, 1'b1, 32'h100 + 4 * k, 32'hC0DE_0000 + k, 4'hF);
    drain(1);
    for (int k = 0; k < 6; k++) issue(1, 1'b0, 32'h100 + 4 * k, 32'h0, 4'h0);
    drain(1);

    // Reset with three outstanding reads; memory must survive.
    issue(1, 1'b1, 32'h200, 32'h1357_9BDF, 4'hF);
    drain(1);
    for (int k = 0; k < 3; k++) issue(1, 1'b0, 32'h200, 32'h0, 4'h0);
    reset_a[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_a[1] = 1'b0;
    repeat (3 + 8) @(posedge clk);
    #1;
    issue(1, 1'b0, 32'h200, 32'h0, 4'h0);
    issue(1, 1'b0, 32'h104, 32'h0, 4'h0);
    drain(1);

    // Random-stall instance: seed words, then hold req high for 64 cycles.
    for (int k = 0; k < 8; k++) issue(2, 1'b1, 32'h300 + 4 * k, 32'h9000_0000 + k, 4'hF);
    for (int n = 0; n < 64; n++) begin
      req_a[2]   = 1'b1;
      wr_a[2]    = 1'($urandom_range(0, 1));
      addr_a[2]  = 32'h300 + 4 * $urandom_range(0, 7);
      wdata_a[2] = $urandom;
      wstrb_a[2] = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
    end
    req_a[2] = 1'b0;
    drain(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
